// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 single-port word SRAM slave with round-robin read/write arbitration

module axi_sram_slave #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DLY_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_RESP
    } state_t;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    state_t            state;
    logic              last_rd;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [7:0]        len;
    logic [7:0]        beat;
    logic [DLY_W-1:0]  dly;
    logic              err;
    logic              w_fire;
    logic              last_beat;
    logic              wlast_err;
    logic              unused_bits;

    assign unused_bits = ^{arsize, awsize, wid, araddr[31:ADDR_W+2], araddr[1:0],
                           awaddr[31:ADDR_W+2], awaddr[1:0]};

    // Readies are gated by aresetn so they drop the moment reset asserts.
    assign arready = aresetn && (state == IDLE) && (!last_rd || !awvalid);
    assign awready = aresetn && (state == IDLE) && (last_rd || !arvalid);

    assign rresp     = 2'b00;
    assign idx_nxt   = idx + ADDR_W'(1);
    assign w_fire    = (state == WR_DATA) && wvalid && wready;
    assign last_beat = (beat == len);
    assign wlast_err = (wlast != last_beat);

    // RAM is not reset so completed writes survive an aresetn pulse.
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            last_rd <= 1'b0;
            idx     <= '0;
            len     <= '0;
            beat    <= '0;
            dly     <= '0;
            err     <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
            wready  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            bvalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arvalid && arready) begin
                        rid     <= arid;
                        idx     <= araddr[ADDR_W+1:2];
                        len     <= arlen;
                        beat    <= '0;
                        dly     <= DLY_W'(RD_LAT - 1);
                        last_rd <= 1'b1;
                        if (RD_LAT == 1) begin
                            rdata  <= mem[araddr[ADDR_W+1:2]];
                            rvalid <= 1'b1;
                            rlast  <= (arlen == 8'd0);
                            state  <= RD_RESP;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end else if (awvalid && awready) begin
                        bid     <= awid;
                        idx     <= awaddr[ADDR_W+1:2];
                        len     <= awlen;
                        beat    <= '0;
                        err     <= 1'b0;
                        last_rd <= 1'b0;
                        wready  <= 1'b1;
                        state   <= WR_DATA;
                    end
                end
                RD_WAIT: begin
                    dly <= dly - DLY_W'(1);
                    if (dly == DLY_W'(1)) begin
                        rdata  <= mem[idx];
                        rvalid <= 1'b1;
                        rlast  <= (len == 8'd0);
                        state  <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            idx   <= idx_nxt;
                            beat  <= beat + 8'd1;
                            rdata <= mem[idx_nxt];
                            rlast <= ((beat + 8'd1) == len);
                        end
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        idx  <= idx_nxt;
                        beat <= beat + 8'd1;
                        // The beat count ends the burst; a misplaced wlast only flags an error.
                        if (last_beat) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= (err || wlast_err) ? 2'b10 : 2'b00;
                            state  <= WR_RESP;
                        end else begin
                            err <= err || wlast_err;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
